// File: rtl/m74hc646_xcvr.sv
// rtl/m74hc646_xcvr.sv - registered bidirectional bus transceiver with per-direction storage
// Each direction drives either the live opposite bus or its stored word, optionally inverted.
module m74hc646_xcvr #(
  parameter int WIDTH    = 8,
  parameter int INVERT   = 0,
  parameter int OE_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  inout  wire  [WIDTH-1:0]    A,
  inout  wire  [WIDTH-1:0]    B,
  input  logic                CAB,
  input  logic                CBA,
  input  logic                SAB,
  input  logic                SBA,
  input  logic                DIR,
  input  logic [OE_WIDTH-1:0] OEn,
  output logic [WIDTH-1:0]    reg_ab_o,
  output logic [WIDTH-1:0]    reg_ba_o
);

  localparam logic [WIDTH-1:0] INV_MASK = (INVERT != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] reg_ab;
  logic [WIDTH-1:0] reg_ba;
  logic             cab_q;
  logic             cba_q;
  logic             en;
  logic [WIDTH-1:0] b_drive;
  logic [WIDTH-1:0] a_drive;

  // Strobe history resets high so a strobe held through reset release is not a rising edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_ab <= '0;
      reg_ba <= '0;
      cab_q  <= 1'b1;
      cba_q  <= 1'b1;
    end else begin
      cab_q <= CAB;
      cba_q <= CBA;
      if (CAB && !cab_q) reg_ab <= A;
      if (CBA && !cba_q) reg_ba <= B;
    end
  end

  always_comb begin
    en      = (OEn == '0);
    b_drive = (SAB ? reg_ab : A) ^ INV_MASK;
    a_drive = (SBA ? reg_ba : B) ^ INV_MASK;
  end

  assign B = (en && DIR)  ? b_drive : {WIDTH{1'bz}};
  assign A = (en && !DIR) ? a_drive : {WIDTH{1'bz}};

  assign reg_ab_o = reg_ab;
  assign reg_ba_o = reg_ba;

endmodule

// File: tb/tb_m74hc646_xcvr.sv
// tb/tb_m74hc646_xcvr.sv - directed bench for m74hc646_xcvr, non-inverting and inverting instances
// Buses are pulled up, so an undriven bus reads all ones.
module tb_m74hc646_xcvr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cab, cba, sab, sba, dir;
  logic [1:0] oen;
  logic       a_en, b_en;
  logic [7:0] a_val, b_val;

  tri1 [7:0] a0, b0, a1, b1;
  logic [7:0] rab0, rba0, rab1, rba1;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ab [2];
  logic [7:0] m_ba [2];
  logic       cab_prev, cba_prev;

  always #5 clk = ~clk;

  assign a0 = a_en ? a_val : 8'bz;
  assign a1 = a_en ? a_val : 8'bz;
  assign b0 = b_en ? b_val : 8'bz;
  assign b1 = b_en ? b_val : 8'bz;

  m74hc646_xcvr #(.WIDTH(8), .INVERT(0), .OE_WIDTH(2)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .A(a0), .B(b0), .CAB(cab), .CBA(cba),
    .SAB(sab), .SBA(sba), .DIR(dir), .OEn(oen), .reg_ab_o(rab0), .reg_ba_o(rba0));

  m74hc646_xcvr #(.WIDTH(8), .INVERT(1), .OE_WIDTH(2)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .A(a1), .B(b1), .CAB(cab), .CBA(cba),
    .SAB(sab), .SBA(sba), .DIR(dir), .OEn(oen), .reg_ab_o(rab1), .reg_ba_o(rba1));

  function automatic logic [7:0] f(input int i, input logic [7:0] x);
    return (i == 1) ? ~x : x;
  endfunction

  // Resolved bus value as seen by instance i, from the rules of the part.
  function automatic logic [7:0] res_a(input int i);
    if (a_en) return a_val;
    if (oen == 2'b00 && !dir) return f(i, sba ? m_ba[i] : (b_en ? b_val : 8'hFF));
    return 8'hFF;
  endfunction

  function automatic logic [7:0] res_b(input int i);
    if (b_en) return b_val;
    if (oen == 2'b00 && dir) return f(i, sab ? m_ab[i] : (a_en ? a_val : 8'hFF));
    return 8'hFF;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ab[i] = 8'h00;
      m_ba[i] = 8'h00;
    end
    cab_prev = 1'b1;
    cba_prev = 1'b1;
  endtask

  task automatic tick();
    logic [7:0] nab [2];
    logic [7:0] nba [2];
    for (int i = 0; i < 2; i++) begin
      nab[i] = (cab && !cab_prev) ? res_a(i) : m_ab[i];
      nba[i] = (cba && !cba_prev) ? res_b(i) : m_ba[i];
    end
    @(posedge clk);
    if (rst_n) begin
      m_ab = nab;
      m_ba = nba;
      cab_prev = cab;
      cba_prev = cba;
    end else begin
      model_reset();
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!a_en) begin
      chk("a0_model", a0, res_a(0));
      chk("a1_model", a1, res_a(1));
    end
    if (!b_en) begin
      chk("b0_model", b0, res_b(0));
      chk("b1_model", b1, res_b(1));
    end
    chk("rab0_model", rab0, m_ab[0]);
    chk("rba0_model", rba0, m_ba[0]);
    chk("rab1_model", rab1, m_ab[1]);
    chk("rba1_model", rba1, m_ba[1]);
  end

  initial begin
    rst_n = 1'b0; oen = 2'b11; dir = 1'b0; sab = 1'b0; sba = 1'b0;
    cab = 1'b1; cba = 1'b0;
    a_en = 1'b1; a_val = 8'h5A; b_en = 1'b0; b_val = 8'h00;
    model_reset();
    tick(); tick();
    chk("reset_rab", rab0, 8'h00);
    chk("reset_rba", rba0, 8'h00);
    chk("reset_b_z", b0, 8'hFF);

    rst_n = 1'b1;
    tick(); tick();
    chk("release_no_load", rab0, 8'h00);
    cab = 1'b0;
    tick();

    oen = 2'b00; dir = 1'b1; sab = 1'b0; a_val = 8'h3C;
    #1;
    chk("live_ab", b0, 8'h3C);
    chk("live_ab_inv", b1, 8'hC3);
    dir = 1'b0; sba = 1'b0; a_en = 1'b0; b_en = 1'b1; b_val = 8'hC3;
    #1;
    chk("live_ba", a0, 8'hC3);
    chk("live_ba_inv", a1, 8'h3C);
    tick();

    oen = 2'b11; dir = 1'b1; a_en = 1'b1; b_en = 1'b0; a_val = 8'hA5; cab = 1'b1;
    tick();
    chk("store_rab", rab0, 8'hA5);
    chk("store_rab_inv", rab1, 8'hA5);
    a_val = 8'h00; sab = 1'b1; oen = 2'b00;
    #1;
    chk("replay_b", b0, 8'hA5);
    chk("replay_b_inv", b1, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      a_val = 8'(k + 1);
      tick();
    end
    chk("held_strobe", rab0, 8'hA5);

    // Capture from the bus this block is driving itself
    cba = 1'b1;
    tick();
    chk("self_capture", rba0, 8'hA5);
    chk("self_capture_inv", rba1, 8'h5A);
    cab = 1'b0; cba = 1'b0;
    tick();

    oen = 2'b11; a_val = 8'h11; b_en = 1'b1; b_val = 8'h22; cab = 1'b1; cba = 1'b1;
    tick();
    chk("simul_rab", rab0, 8'h11);
    chk("simul_rba", rba0, 8'h22);
    cab = 1'b0; cba = 1'b0;
    tick();

    b_val = 8'h0F; cba = 1'b1;
    tick();
    cba = 1'b0;
    tick();
    dir = 1'b0; sba = 1'b1; oen = 2'b00; a_en = 1'b0;
    #1;
    chk("stored_inv_a", a1, 8'hF0);
    chk("stored_a", a0, 8'h0F);
    chk("inv_reg_plain", rba1, 8'h0F);
    oen = 2'b01;
    #1;
    chk("partial_en_z", a1, 8'hFF);
    tick();

    oen = 2'b11; a_en = 1'b1; b_en = 1'b0; a_val = 8'hA5; cab = 1'b1;
    tick();
    cab = 1'b0;
    tick();
    dir = 1'b1; sab = 1'b1; oen = 2'b00; a_val = 8'h00;
    #1;
    chk("pre_reset_b", b0, 8'hA5);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_b", b0, 8'h00);
    chk("async_b_inv", b1, 8'hFF);
    chk("async_rab", rab0, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    oen = 2'b11;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m74hc646_xcvr.md
# m74hc646_xcvr

Parametrised registered bus transceiver for the discrete-logic model library. It is the clocked successor to the plain tri-state inverting buffer. Each direction has a storage register, each loaded on a rising edge of its own strobe. Each output port drives either live input data or the stored word, with optional inversion, and tri-states under active-low enables. Used on the 4-bit CPU environment board model between the CPU data bus and peripheral buses, where data must be latched and replayed.

## Interface
- WIDTH, 8: data width of ports A and B and of both registers.
- INVERT, 0: 1 inverts every driven output bit; registers always hold non-inverted data.
- OE_WIDTH, 2: number of active-low enables; outputs are enabled only when all are 0.
- clk_i  input  1  single clock, all state on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- A  inout  WIDTH  bus A; input when DIR=0 is not in force, driven when enabled and DIR=0.
- B  inout  WIDTH  bus B; driven when enabled and DIR=1.
- CAB  input  1  strobe; rising edge loads reg_ab from A.
- CBA  input  1  strobe; rising edge loads reg_ba from B.
- SAB  input  1  B source: 0 = live A, 1 = reg_ab.
- SBA  input  1  A source: 0 = live B, 1 = reg_ba.
- DIR  input  1  1 = A→B (drive B), 0 = B→A (drive A).
- OEn  input  OE_WIDTH  active-low output enables.
- reg_ab_o  output  WIDTH  current reg_ab contents (non-inverted).
- reg_ba_o  output  WIDTH  current reg_ba contents (non-inverted).

## Operation
- State: reg_ab, reg_ba (WIDTH each); cab_q, cba_q (strobe history, 1 bit each).
- Reset (rst_n_i=0, asynchronous):
  - reg_ab = reg_ba = 0, cab_q = cba_q = 1.
  - A strobe held high through reset release therefore does not load.
- Every clk_i edge: cab_q <= CAB, cba_q <= CBA.
- Load rule:
  - CAB=1 and cab_q=0 at an edge: reg_ab <= resolved value on A at that edge.
  - CBA=1 and cba_q=0 at an edge: reg_ba <= resolved value on B at that edge.
  - Otherwise the register holds.
- Loads are independent of DIR, OEn, SAB and SBA. Loading from the port the block itself drives captures the driven value, including any inversion.
- en = (OEn == 0), all bits.
- Output selection:
  - en=1, DIR=1: B = f(SAB ? reg_ab : A); A not driven (Z).
  - en=1, DIR=0: A = f(SBA ? reg_ba : B); B not driven (Z).
  - en=0: A and B both Z.
  - f(x) = INVERT ? ~x : x.
- The output path is purely combinational from its selects, registers and the opposite port. There is no combinational loop, because only one port is driven at a time.
- Strobes are single-bit level inputs sampled by clk_i. A strobe high for N cycles gives exactly one load, on its first high edge.

## Timing
- Live path (SAB/SBA=0): zero-cycle latency, A→B or B→A combinational.
- Strobe latency: if CAB is first seen high at edge k (low at k-1), reg_ab holds A(k) immediately after edge k. Stored-mode B shows it in the same cycle.
- A strobe pulse shorter than one clk_i period between edges may be missed; the minimum strobe width is one full clock period low and one high.
- Simultaneous CAB and CBA rising edges: both registers load at the same edge.
- DIR, OEn, SAB and SBA changes take effect combinationally in the same cycle with no state change.
- Reset mid-operation: registers clear immediately, without waiting for clk_i. A stored-mode output goes to 0 (all ones if INVERT=1) at once, and the enable/Z behaviour continues to follow OEn.

## Test plan
- Reset and tri-state: rst_n_i=0, OEn=2'b11, A driven 8'h5A -> reg_ab_o=reg_ba_o=8'h00, B=Z. Release reset with CAB=1 held -> no load, reg_ab_o stays 8'h00.
- Live pass, INVERT=0: OEn=0, DIR=1, SAB=0, A=8'h3C -> B=8'h3C same cycle. DIR=0, SBA=0, B=8'hC3 -> A=8'hC3, B undriven by block.
- Store and replay: A=8'hA5, CAB 0→1 -> reg_ab_o=8'hA5 after that edge. A changed to 8'h00, SAB=1, DIR=1, OEn=0 -> B=8'hA5. CAB held high 5 cycles -> no further loads.
- Simultaneous loads: A=8'h11, B=8'h22, CAB and CBA rise on the same edge, OEn=2'b11 -> reg_ab_o=8'h11, reg_ba_o=8'h22.
- Inversion, INVERT=1: reg_ba=8'h0F, DIR=0, SBA=1, OEn=0 -> A=8'hF0; reg_ba_o still 8'h0F. Partial enable OEn=2'b01 -> A=Z.
- Async reset mid-replay: stored mode driving B=8'hA5, assert rst_n_i between clock edges -> B=8'h00 before the next edge, reg_ab_o=8'h00.
